// File: rtl/command_writer.sv
// command_writer: Avalon-MM write master that drains a 64-bit word stream into a ring buffer.
// While the bus is stalled one word waits in the output register, so up to FIFO_DEPTH+1 words are accepted before fifo_full.
module command_writer #(
    parameter int unsigned CMD_ADDRESS     = 0,
    parameter int unsigned BUFFER_WORDS    = 1024,
    parameter int unsigned FIFO_DEPTH      = 32,
    parameter int unsigned FIFO_DEPTH_LOG2 = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        restart,
    output logic        ready,
    output logic        idle,
    output logic [31:0] words_written,
    output logic [28:0] write_address,
    output logic [7:0]  write_burstcount,
    output logic [7:0]  write_byteenable,
    output logic [63:0] write_writedata,
    output logic        write_write,
    input  logic        write_waitrequest,
    input  logic [63:0] fifo_data,
    input  logic        fifo_wrreq,
    output logic        fifo_full
);

    localparam logic [28:0] BASE_WORD = 29'(CMD_ADDRESS / 8);
    localparam logic [28:0] LAST_WORD = 29'(CMD_ADDRESS / 8 + BUFFER_WORDS - 1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_LAST  = FIFO_DEPTH_LOG2'(FIFO_DEPTH - 1);
    localparam logic [FIFO_DEPTH_LOG2:0]   USED_FULL = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        INIT       = 2'd0,
        COPY       = 2'd1,
        WAIT_WRITE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [63:0]                fifo_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2:0]   used;
    logic [63:0]                fifo_head;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;
    logic                       load;
    logic                       drop_write;
    logic                       init_clear;
    logic                       bus_free;
    logic                       write_accepted;
    logic [28:0]                next_word;

    assign write_burstcount = 8'h01;
    assign write_byteenable = 8'hFF;

    assign fifo_head      = fifo_mem[rd_ptr];
    assign fifo_empty     = (used == '0);
    assign ready          = (state == COPY) && !restart;
    assign idle           = ready && fifo_empty && !write_write;
    assign fifo_full      = (used == USED_FULL) || !ready;
    assign push           = fifo_wrreq && !fifo_full;
    assign bus_free       = !write_write || !write_waitrequest;
    assign write_accepted = write_write && !write_waitrequest;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        drop_write = 1'b0;
        init_clear = 1'b0;
        case (state)
            INIT: begin
                init_clear = 1'b1;
                if (!restart) begin
                    state_next = COPY;
                end
            end
            COPY: begin
                if (restart) begin
                    // a stalled write must stay on the bus until the slave takes it
                    if (write_write && write_waitrequest) begin
                        state_next = WAIT_WRITE;
                    end else begin
                        drop_write = 1'b1;
                        state_next = INIT;
                    end
                end else if (bus_free) begin
                    if (!fifo_empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        drop_write = 1'b1;
                    end
                end
            end
            WAIT_WRITE: begin
                if (!write_waitrequest) begin
                    drop_write = 1'b1;
                    state_next = INIT;
                end
            end
            default: begin
                drop_write = 1'b1;
                state_next = INIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= fifo_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || init_clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            used   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || init_clear) begin
            words_written <= '0;
        end else if (write_accepted) begin
            words_written <= words_written + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            write_write     <= 1'b0;
            write_writedata <= '0;
            write_address   <= BASE_WORD;
            next_word       <= BASE_WORD;
        end else begin
            if (init_clear) begin
                next_word <= BASE_WORD;
            end
            if (load) begin
                write_write     <= 1'b1;
                write_writedata <= fifo_head;
                write_address   <= next_word;
                next_word       <= (next_word == LAST_WORD) ? BASE_WORD : next_word + 29'd1;
            end else if (drop_write) begin
                write_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_command_writer.sv
// Scoreboard bench for command_writer: expected (address, data) pairs are queued on enqueue
// and popped by an independent monitor whenever the slave accepts a write.
module tb_command_writer;

    localparam int unsigned TB_BASE  = 32'h100;
    localparam int unsigned TB_WORDS = 4;
    localparam int unsigned TB_DEPTH = 32;
    localparam logic [28:0] BASE_W   = 29'(TB_BASE / 8);

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        restart = 1'b0;
    logic        write_waitrequest = 1'b0;
    logic        fifo_wrreq = 1'b0;
    logic [63:0] fifo_data = '0;
    logic        ready;
    logic        idle;
    logic        write_write;
    logic        fifo_full;
    logic [31:0] words_written;
    logic [28:0] write_address;
    logic [7:0]  write_burstcount;
    logic [7:0]  write_byteenable;
    logic [63:0] write_writedata;

    command_writer #(
        .CMD_ADDRESS(TB_BASE),
        .BUFFER_WORDS(TB_WORDS),
        .FIFO_DEPTH(TB_DEPTH),
        .FIFO_DEPTH_LOG2(5)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .restart(restart),
        .ready(ready),
        .idle(idle),
        .words_written(words_written),
        .write_address(write_address),
        .write_burstcount(write_burstcount),
        .write_byteenable(write_byteenable),
        .write_writedata(write_writedata),
        .write_write(write_write),
        .write_waitrequest(write_waitrequest),
        .fifo_data(fifo_data),
        .fifo_wrreq(fifo_wrreq),
        .fifo_full(fifo_full)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [28:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int unsigned seq = 0;
    bit          mon_prev_stall = 1'b0;
    logic [28:0] mon_prev_addr = '0;
    logic [63:0] mon_prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // ring position of the n-th word since the last rewind
    function automatic logic [28:0] model_addr(input int unsigned n);
        return BASE_W + 29'(n % TB_WORDS);
    endfunction

    task automatic expect_word(input logic [63:0] d);
        exp_t e;
        e.addr = model_addr(seq);
        e.data = d;
        exp_q.push_back(e);
        seq++;
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            mon_prev_stall = 1'b0;
        end else begin
            if (mon_prev_stall) begin
                check("stall_write_held", 64'(write_write), 64'd1);
                check("stall_addr_held", 64'(write_address), 64'(mon_prev_addr));
                check("stall_data_held", write_writedata, mon_prev_data);
            end
            if (write_write && !write_waitrequest) begin
                check("burstcount", 64'(write_burstcount), 64'h01);
                check("byteenable", 64'(write_byteenable), 64'hFF);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                             write_address, write_writedata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", 64'(write_address), 64'(mon_e.addr));
                    check("write_data", write_writedata, mon_e.data);
                end
            end
            mon_prev_stall = write_write && write_waitrequest;
            mon_prev_addr  = write_address;
            mon_prev_data  = write_writedata;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [63:0] d);
        bit ok = 1'b0;
        fifo_data  = d;
        fifo_wrreq = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clock);
            if (!fifo_full) begin
                expect_word(d);
                ok = 1'b1;
            end
            step();
        end
        fifo_wrreq = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got never accepted, required accepted");
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && idle) done = 1'b1;
        end
        check("drain_complete", 64'(done), 64'd1);
        step();
    endtask

    task automatic wait_ready(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (ready) done = 1'b1;
        end
        check(name, 64'(done), 64'd1);
        step();
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clock);
        check("restart_ready_low", 64'(ready), 64'd0);
        check("restart_full_high", 64'(fifo_full), 64'd1);
        step();
        restart = 1'b0;
        exp_q.delete();
        seq = 0;
        wait_ready("restart_ready_return");
        check("restart_words_zero", 64'(words_written), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;

        // reset values and release timing
        reset_n = 1'b0;
        repeat (3) step();
        @(negedge clock);
        check("rst_write", 64'(write_write), 64'd0);
        check("rst_data", write_writedata, 64'd0);
        check("rst_addr", 64'(write_address), 64'(BASE_W));
        check("rst_words", 64'(words_written), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_full", 64'(fifo_full), 64'd1);
        check("rst_idle", 64'(idle), 64'd0);
        step();
        reset_n = 1'b1;
        @(negedge clock);
        check("release_ready_first", 64'(ready), 64'd0);
        step();
        @(negedge clock);
        check("release_ready_second", 64'(ready), 64'd1);
        check("release_idle", 64'(idle), 64'd1);
        check("release_full", 64'(fifo_full), 64'd0);
        step();

        // four back-to-back words, no stalls
        push_word(64'h1111_1111_1111_1111);
        push_word(64'h2222_2222_2222_2222);
        push_word(64'h3333_3333_3333_3333);
        push_word(64'h4444_4444_4444_4444);
        wait_drain();
        check("t1_words", 64'(words_written), 64'd4);
        check("t1_idle", 64'(idle), 64'd1);

        // single word onto an empty FIFO appears two cycles after enqueue
        do_restart();
        push_word(64'hCAFE_0000_0000_0001);
        @(negedge clock);
        check("lat_not_yet", 64'(write_write), 64'd0);
        step();
        @(negedge clock);
        check("lat_write_up", 64'(write_write), 64'd1);
        step();
        wait_drain();

        // five-cycle stall on the second write
        do_restart();
        push_word(64'hA000_0000_0000_0001);
        push_word(64'hA000_0000_0000_0002);
        push_word(64'hA000_0000_0000_0003);
        write_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t2_stall_write", 64'(write_write), 64'd1);
            step();
        end
        write_waitrequest = 1'b0;
        wait_drain();
        check("t2_words", 64'(words_written), 64'd3);

        // ring wrap over four words
        do_restart();
        for (int i = 0; i < 6; i++) push_word(64'hB0 + 64'(i));
        wait_drain();
        check("t3_words", 64'(words_written), 64'd6);

        // overflow with the bus stalled
        do_restart();
        write_waitrequest = 1'b1;
        fifo_wrreq = 1'b1;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            fifo_data = 64'hF000 + 64'(i);
            @(negedge clock);
            if (!fifo_full) begin
                expect_word(fifo_data);
                acc++;
            end
            step();
        end
        fifo_wrreq = 1'b0;
        @(negedge clock);
        check("t4_full", 64'(fifo_full), 64'd1);
        check("t4_accepted", 64'(acc), 64'(TB_DEPTH + 1));
        step();
        write_waitrequest = 1'b0;
        wait_drain();
        check("t4_words", 64'(words_written), 64'(TB_DEPTH + 1));

        // restart while a write is stalled with ten words queued behind it
        do_restart();
        write_waitrequest = 1'b1;
        for (int i = 0; i < 11; i++) push_word(64'hD000 + 64'(i));
        step();
        step();
        restart = 1'b1;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t5_ready_low", 64'(ready), 64'd0);
            check("t5_write_held", 64'(write_write), 64'd1);
            step();
        end
        write_waitrequest = 1'b0;
        @(negedge clock);
        step();
        @(negedge clock);
        check("t5_held_counted", 64'(words_written), 64'd1);
        check("t5_write_dropped", 64'(write_write), 64'd0);
        step();
        restart = 1'b0;
        wait_ready("t5_ready_return");
        check("t5_words_zero", 64'(words_written), 64'd0);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        seq = 0;
        push_word(64'hD0D0_D0D0_D0D0_D0D0);
        wait_drain();
        check("t5_words_after", 64'(words_written), 64'd1);

        // one-cycle reset in the middle of stalled traffic
        write_waitrequest = 1'b1;
        fifo_wrreq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fifo_data = 64'hE000 + 64'(i);
            @(negedge clock);
            if (!fifo_full) expect_word(fifo_data);
            step();
        end
        fifo_wrreq = 1'b0;
        reset_n = 1'b0;
        exp_q.delete();
        seq = 0;
        step();
        reset_n = 1'b1;
        write_waitrequest = 1'b0;
        @(negedge clock);
        check("t6_write", 64'(write_write), 64'd0);
        check("t6_data", write_writedata, 64'd0);
        check("t6_addr", 64'(write_address), 64'(BASE_W));
        check("t6_words", 64'(words_written), 64'd0);
        check("t6_ready_first", 64'(ready), 64'd0);
        check("t6_full", 64'(fifo_full), 64'd1);
        step();
        @(negedge clock);
        check("t6_ready_second", 64'(ready), 64'd1);
        check("t6_idle", 64'(idle), 64'd1);
        step();

        // randomized traffic with random stalls
        do_restart();
        for (int i = 0; i < 400; i++) begin
            fifo_wrreq = 1'($urandom_range(0, 1));
            fifo_data = {$urandom, $urandom};
            write_waitrequest = (i % 100 < 30) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            @(negedge clock);
            if (fifo_wrreq && !fifo_full) expect_word(fifo_data);
            step();
        end
        fifo_wrreq = 1'b0;
        write_waitrequest = 1'b0;
        wait_drain();
        check("rand_words", 64'(words_written), 64'(seq));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
